// File: rtl/kamacore_stage_mem.sv
// Memory stage: runs RV32I loads/stores on a req/gnt/rvalid port; everything else goes straight to MEM->WB.
// Latency: pass-through 1 cycle, store 1 cycle after gnt, load 1 cycle after rvalid; EX is stalled (ready low) while busy.
module kamacore_stage_mem #(
    parameter int CPU_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_mem_valid,
    output logic                 ex_mem_ready,
    input  logic [CPU_WIDTH-1:0] ex_mem_alu_result,
    input  logic [CPU_WIDTH-1:0] ex_mem_rs2_data,
    input  logic [31:0]          ex_mem_instruction,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [CPU_WIDTH-1:0] dmem_addr,
    output logic [3:0]           dmem_be,
    output logic [CPU_WIDTH-1:0] dmem_wdata,
    input  logic                 dmem_gnt,
    input  logic                 dmem_rvalid,
    input  logic [CPU_WIDTH-1:0] dmem_rdata,
    output logic                 mem_wb_valid,
    output logic [CPU_WIDTH-1:0] mem_wb_result,
    output logic [31:0]          mem_wb_instruction,
    output logic                 mem_wb_fault
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CPU_WIDTH-1:0] lat_ea;
    logic [31:0]          lat_instr;

    // Decode of the incoming EX->MEM entry.
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic                 is_load, is_store;
    logic                 misalign, illegal, acc_fault;
    logic [3:0]           st_be;
    logic [CPU_WIDTH-1:0] st_wdata;

    always_comb begin
        opcode   = ex_mem_instruction[6:0];
        funct3   = ex_mem_instruction[14:12];
        is_load  = (opcode == 7'b0000011);
        is_store = (opcode == 7'b0100011);
        misalign = ((funct3[1:0] == 2'b01) && ex_mem_alu_result[0]) ||
                   ((funct3[1:0] == 2'b10) && (ex_mem_alu_result[1:0] != 2'b00));
        illegal  = (is_load  && ((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111))) ||
                   (is_store && (funct3 >= 3'b011));
        acc_fault = (is_load || is_store) && (misalign || illegal);
        case (funct3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << ex_mem_alu_result[1:0];
                st_wdata = {4{ex_mem_rs2_data[7:0]}};
            end
            2'b01: begin
                st_be    = ex_mem_alu_result[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{ex_mem_rs2_data[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = ex_mem_rs2_data;
            end
        endcase
    end

    // Lane select and extension of returned load data, using the latched address/funct3.
    logic [7:0]           ld_byte;
    logic [15:0]          ld_half;
    logic [CPU_WIDTH-1:0] ld_ext;
    logic [2:0]           lat_f3;

    always_comb begin
        lat_f3 = lat_instr[14:12];
        case (lat_ea[1:0])
            2'b00:   ld_byte = dmem_rdata[7:0];
            2'b01:   ld_byte = dmem_rdata[15:8];
            2'b10:   ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = lat_ea[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (lat_f3)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = dmem_rdata;
        endcase
    end

    logic accept_access, wb_pass, wb_store, wb_load;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        ex_mem_ready  = 1'b0;
        dmem_req      = 1'b0;
        accept_access = 1'b0;
        wb_pass       = 1'b0;
        wb_store      = 1'b0;
        wb_load       = 1'b0;
        case (state)
            IDLE: begin
                ex_mem_ready = 1'b1;
                if (ex_mem_valid && (is_load || is_store) && !acc_fault) begin
                    accept_access = 1'b1;
                    state_nxt     = REQ;
                end else begin
                    wb_pass = 1'b1;
                end
            end
            REQ: begin
                dmem_req = 1'b1;
                if (dmem_gnt) begin
                    if (dmem_we) begin
                        wb_store  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (dmem_rvalid) begin
                    wb_load   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields are latched on accept so they stay stable until gnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_ea     <= '0;
            lat_instr  <= '0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= 4'b0000;
            dmem_wdata <= '0;
        end else if (accept_access) begin
            lat_ea     <= ex_mem_alu_result;
            lat_instr  <= ex_mem_instruction;
            dmem_we    <= is_store;
            dmem_addr  <= {ex_mem_alu_result[CPU_WIDTH-1:2], 2'b00};
            dmem_be    <= is_store ? st_be : 4'b1111;
            dmem_wdata <= is_store ? st_wdata : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wb_valid       <= 1'b0;
            mem_wb_result      <= '0;
            mem_wb_instruction <= '0;
            mem_wb_fault       <= 1'b0;
        end else begin
            mem_wb_valid <= 1'b0;
            mem_wb_fault <= 1'b0;
            if (wb_pass && ex_mem_valid) begin
                mem_wb_valid       <= 1'b1;
                mem_wb_result      <= ex_mem_alu_result;
                mem_wb_instruction <= ex_mem_instruction;
                mem_wb_fault       <= acc_fault;
            end else if (wb_store) begin
                mem_wb_valid       <= 1'b1;
                mem_wb_result      <= lat_ea;
                mem_wb_instruction <= lat_instr;
            end else if (wb_load) begin
                mem_wb_valid       <= 1'b1;
                mem_wb_result      <= ld_ext;
                mem_wb_instruction <= lat_instr;
            end
        end
    end

endmodule

// File: tb/tb_kamacore_stage_mem.sv
// Directed bench for kamacore_stage_mem: inputs change and outputs are sampled on the falling edge.
module tb_kamacore_stage_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_mem_valid;
    logic        ex_mem_ready;
    logic [31:0] ex_mem_alu_result;
    logic [31:0] ex_mem_rs2_data;
    logic [31:0] ex_mem_instruction;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        mem_wb_valid;
    logic [31:0] mem_wb_result;
    logic [31:0] mem_wb_instruction;
    logic        mem_wb_fault;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] I_ADD = 32'h0000_0033;
    localparam logic [31:0] I_SB  = 32'h0000_0023;
    localparam logic [31:0] I_SH  = 32'h0000_1023;
    localparam logic [31:0] I_LB  = 32'h0000_0003;
    localparam logic [31:0] I_LBU = 32'h0000_4003;
    localparam logic [31:0] I_LW  = 32'h0000_2003;

    kamacore_stage_mem #(.CPU_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .ex_mem_valid(ex_mem_valid), .ex_mem_ready(ex_mem_ready),
        .ex_mem_alu_result(ex_mem_alu_result), .ex_mem_rs2_data(ex_mem_rs2_data),
        .ex_mem_instruction(ex_mem_instruction),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .mem_wb_valid(mem_wb_valid), .mem_wb_result(mem_wb_result),
        .mem_wb_instruction(mem_wb_instruction), .mem_wb_fault(mem_wb_fault)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic [31:0] instr, input logic [31:0] ea, input logic [31:0] rs2);
        ex_mem_valid       = 1'b1;
        ex_mem_instruction = instr;
        ex_mem_alu_result  = ea;
        ex_mem_rs2_data    = rs2;
        @(negedge clk);
        ex_mem_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ex_mem_valid = 1'b0; ex_mem_alu_result = '0; ex_mem_rs2_data = '0;
        ex_mem_instruction = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        repeat (2) @(negedge clk);
        total++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !== 70'd0) begin
            bad++; $display("FAIL reset_dmem: got req=%b we=%b addr=%h be=%b wdata=%h, want all 0",
                            dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata);
        end
        total++;
        if ({mem_wb_valid, mem_wb_result, mem_wb_instruction, mem_wb_fault} !== 66'd0) begin
            bad++; $display("FAIL reset_wb: got valid=%b result=%h instr=%h fault=%b, want all 0",
                            mem_wb_valid, mem_wb_result, mem_wb_instruction, mem_wb_fault);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (ex_mem_ready !== 1'b1) begin
            bad++; $display("FAIL reset_ready: got %b want 1", ex_mem_ready);
        end
    endtask

    task automatic test_passthrough(input logic [31:0] val);
        issue(I_ADD, val, 32'hDEAD_BEEF);
        total++;
        if (mem_wb_valid !== 1'b1 || mem_wb_result !== val || mem_wb_instruction !== I_ADD ||
            mem_wb_fault !== 1'b0 || dmem_req !== 1'b0) begin
            bad++; $display("FAIL add_pass: got valid=%b result=%h instr=%h fault=%b req=%b, want 1 %h %h 0 0",
                            mem_wb_valid, mem_wb_result, mem_wb_instruction, mem_wb_fault, dmem_req, val, I_ADD);
        end
        @(negedge clk);
        total++;
        if (mem_wb_valid !== 1'b0 || mem_wb_result !== val) begin
            bad++; $display("FAIL add_hold: got valid=%b result=%h, want 0 %h", mem_wb_valid, mem_wb_result, val);
        end
    endtask

    task automatic test_store_byte();
        int req_cycles = 0;
        issue(I_SB, 32'h0000_0103, 32'h0000_00AB);
        total++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h100 ||
            dmem_be !== 4'b1000 || dmem_wdata !== 32'hABAB_ABAB || ex_mem_ready !== 1'b0) begin
            bad++; $display("FAIL sb_req: got req=%b we=%b addr=%h be=%b wdata=%h ready=%b, want 1 1 100 1000 abababab 0",
                            dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, ex_mem_ready);
        end
        for (int c = 0; c < 3; c++) begin
            if (dmem_req === 1'b1 && ex_mem_ready === 1'b0 && dmem_addr === 32'h100) req_cycles++;
            if (c == 2) dmem_gnt = 1'b1;
            @(negedge clk);
        end
        dmem_gnt = 1'b0;
        total++;
        if (req_cycles != 3) begin
            bad++; $display("FAIL sb_req_hold: got %0d stable request cycles, want 3", req_cycles);
        end
        total++;
        if (dmem_req !== 1'b0 || ex_mem_ready !== 1'b1 || mem_wb_valid !== 1'b1 ||
            mem_wb_result !== 32'h103 || mem_wb_instruction !== I_SB) begin
            bad++; $display("FAIL sb_done: got req=%b ready=%b valid=%b result=%h instr=%h, want 0 1 1 103 %h",
                            dmem_req, ex_mem_ready, mem_wb_valid, mem_wb_result, mem_wb_instruction, I_SB);
        end
    endtask

    task automatic test_store_half();
        issue(I_SH, 32'h0000_0202, 32'h1234_ABCD);
        total++;
        if (dmem_req !== 1'b1 || dmem_addr !== 32'h200 || dmem_be !== 4'b1100 || dmem_wdata !== 32'hABCD_ABCD) begin
            bad++; $display("FAIL sh_req: got req=%b addr=%h be=%b wdata=%h, want 1 200 1100 abcdabcd",
                            dmem_req, dmem_addr, dmem_be, dmem_wdata);
        end
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        total++;
        if (mem_wb_valid !== 1'b1 || mem_wb_result !== 32'h202) begin
            bad++; $display("FAIL sh_done: got valid=%b result=%h, want 1 202", mem_wb_valid, mem_wb_result);
        end
    endtask

    task automatic test_load(input logic [31:0] instr, input logic [31:0] exp, input string name);
        issue(instr, 32'h0000_0102, 32'h0);
        total++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h100 || dmem_be !== 4'b1111) begin
            bad++; $display("FAIL %s_req: got req=%b we=%b addr=%h be=%b, want 1 0 100 1111",
                            name, dmem_req, dmem_we, dmem_addr, dmem_be);
        end
        // rvalid while still in REQ must be ignored
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_1111;
        @(negedge clk);
        dmem_gnt = 1'b0;
        total++;
        if (dmem_req !== 1'b0 || mem_wb_valid !== 1'b0 || ex_mem_ready !== 1'b0) begin
            bad++; $display("FAIL %s_wait: got req=%b valid=%b ready=%b, want 0 0 0",
                            name, dmem_req, mem_wb_valid, ex_mem_ready);
        end
        dmem_rdata = 32'h0080_0000;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        total++;
        if (mem_wb_valid !== 1'b1 || mem_wb_result !== exp || mem_wb_fault !== 1'b0 || ex_mem_ready !== 1'b1) begin
            bad++; $display("FAIL %s_data: got valid=%b result=%h fault=%b ready=%b, want 1 %h 0 1",
                            name, mem_wb_valid, mem_wb_result, mem_wb_fault, ex_mem_ready, exp);
        end
    endtask

    task automatic test_fault();
        int reqs = 0;
        ex_mem_valid = 1'b1; ex_mem_instruction = I_LW; ex_mem_alu_result = 32'h101;
        @(negedge clk);
        ex_mem_valid = 1'b0;
        if (dmem_req !== 1'b0) reqs++;
        total++;
        if (mem_wb_valid !== 1'b1 || mem_wb_fault !== 1'b1 || mem_wb_result !== 32'h101) begin
            bad++; $display("FAIL lw_fault: got valid=%b fault=%b result=%h, want 1 1 101",
                            mem_wb_valid, mem_wb_fault, mem_wb_result);
        end
        @(negedge clk);
        if (dmem_req !== 1'b0) reqs++;
        total++;
        if (reqs != 0 || mem_wb_fault !== 1'b0) begin
            bad++; $display("FAIL lw_fault_noreq: got req_seen=%0d fault=%b, want 0 0", reqs, mem_wb_fault);
        end
        issue(I_SB | 32'h0000_3000, 32'h200, 32'h5);
        total++;
        if (mem_wb_fault !== 1'b1 || dmem_req !== 1'b0) begin
            bad++; $display("FAIL st_illegal: got fault=%b req=%b, want 1 0", mem_wb_fault, dmem_req);
        end
    endtask

    task automatic test_reset_mid();
        issue(I_LW, 32'h0000_0100, 32'h0);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, mem_wb_valid, mem_wb_result,
             mem_wb_instruction, mem_wb_fault} !== 136'd0) begin
            bad++; $display("FAIL rst_mid_outputs: got req=%b addr=%h be=%b valid=%b result=%h, want all 0",
                            dmem_req, dmem_addr, dmem_be, mem_wb_valid, mem_wb_result);
        end
        dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        total++;
        if (mem_wb_valid !== 1'b0 || mem_wb_result !== 32'h0 || ex_mem_ready !== 1'b1) begin
            bad++; $display("FAIL rst_late_rvalid: got valid=%b result=%h ready=%b, want 0 0 1",
                            mem_wb_valid, mem_wb_result, ex_mem_ready);
        end
        test_passthrough(32'h0000_0055);
    endtask

    initial begin
        test_reset();
        test_passthrough(32'h0000_1234);
        test_store_byte();
        test_store_half();
        test_load(I_LB,  32'hFFFF_FF80, "lb");
        test_load(I_LBU, 32'h0000_0080, "lbu");
        test_fault();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
